mem_bus_if: RTL and testbench

Registered memory-access sequencer between the multi-cycle control unit and the memory model. It converts the unit's level-held READ/WRITE strobes into one request/acknowledge transaction per access, supporting variable-latency memory. It captures read data and reports completion with a one-cycle DONE pulse. When enabled, it also reports an access that never completes with a one-cycle ERR pulse.

---
 rtl/mem_bus_if.sv | 140 ++++++++++++++
 tb/tb_mem_bus_if.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_if.sv
// Registered memory-access sequencer: turns level-held READ/WRITE strobes into one M_REQ/M_ACK transaction each.
// Optional macro MEM_BUS_TIMEOUT_EN adds a wait counter that aborts an unacknowledged access with an ERR pulse.
module mem_bus_if #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic [DATA_WIDTH-1:0] WDATA,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR,
    output logic                  M_REQ,
    output logic                  M_WE,
    output logic [ADDR_WIDTH-1:0] M_ADDR,
    output logic [DATA_WIDTH-1:0] M_WDATA,
    input  logic [DATA_WIDTH-1:0] M_RDATA,
    input  logic                  M_ACK
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
`ifdef MEM_BUS_TIMEOUT_EN
    localparam logic [1:0] ST_ERR    = 2'd3;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic [1:0]            state_q, state_d;
    logic [1:0]            last_op_q, last_op_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  req_q, busy_q, done_q, err_q;

    logic [1:0] op;
    logic       op_valid;
    logic       start;

    assign op       = {READ, WRITE};
    assign op_valid = (op == 2'b10) || (op == 2'b01);
    // A held strobe matches last_op and is not restarted; a no-op re-arms it.
    assign start    = op_valid && (op != last_op_q);

    always_comb begin
        state_d   = state_q;
        last_op_d = op_valid ? last_op_q : 2'b00;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
`ifdef MEM_BUS_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d    = ADDR;
                    wdata_d   = WDATA;
                    we_d      = (op == 2'b01);
                    last_op_d = op;
`ifdef MEM_BUS_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (M_ACK) begin
                    if (!we_q) begin
                        rdata_d = M_RDATA;
                    end
                    state_d = ST_DONE;
                end else begin
`ifdef MEM_BUS_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d = ST_ERR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            last_op_q <= 2'b00;
            rdata_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            last_op_q <= last_op_d;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            // Status outputs are decoded from the next state so they align with it.
            req_q     <= (state_d == ST_ACCESS);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
`ifdef MEM_BUS_TIMEOUT_EN
            err_q     <= (state_d == ST_ERR);
            cnt_q     <= cnt_d;
`else
            err_q     <= 1'b0;
`endif
        end
    end

    assign RDATA   = rdata_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign ERR     = err_q;
    assign M_REQ   = req_q;
    assign M_WE    = we_q;
    assign M_ADDR  = addr_q;
    assign M_WDATA = wdata_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed self-checking bench for mem_bus_if; the timeout section follows MEM_BUS_TIMEOUT_EN.
module tb_mem_bus_if;

    logic        CLK = 1'b0;
    logic        RST;
    logic        READ, WRITE;
    logic [25:0] ADDR;
    logic [31:0] WDATA;
    logic [31:0] RDATA;
    logic        BUSY, DONE, ERR, M_REQ, M_WE;
    logic [25:0] M_ADDR;
    logic [31:0] M_WDATA;
    logic [31:0] M_RDATA;
    logic        M_ACK;

    int tests_run    = 0;
    int tests_failed = 0;

    mem_bus_if #(.ADDR_WIDTH(26), .DATA_WIDTH(32), .TIMEOUT(15)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .READ    (READ),
        .WRITE   (WRITE),
        .ADDR    (ADDR),
        .WDATA   (WDATA),
        .RDATA   (RDATA),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ERR     (ERR),
        .M_REQ   (M_REQ),
        .M_WE    (M_WE),
        .M_ADDR  (M_ADDR),
        .M_WDATA (M_WDATA),
        .M_RDATA (M_RDATA),
        .M_ACK   (M_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int accesses;
        int n;
        logic prev_req;

        RST = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDR = '0; WDATA = '0;
        M_RDATA = '0; M_ACK = 1'b0;
        step(); step();
        RST = 1'b0;
        chk("rst_rdata", RDATA, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        chk("rst_req", M_REQ, 0);
        chk("rst_we", M_WE, 0);
        chk("rst_addr", M_ADDR, 0);
        chk("rst_wdata", M_WDATA, 0);

        // Zero-wait read
        ADDR = 26'h0000010; READ = 1'b1; M_ACK = 1'b1; M_RDATA = 32'hDEADBEEF;
        step();
        chk("zw_req_k", M_REQ, 1);
        chk("zw_busy_k", BUSY, 1);
        chk("zw_we_k", M_WE, 0);
        chk("zw_addr_k", M_ADDR, 26'h0000010);
        chk("zw_done_k", DONE, 0);
        step();
        M_ACK = 1'b0;
        chk("zw_req_k1", M_REQ, 0);
        chk("zw_done_k1", DONE, 1);
        chk("zw_rdata_k1", RDATA, 32'hDEADBEEF);
        chk("zw_busy_k1", BUSY, 1);
        step();
        chk("zw_done_k2", DONE, 0);
        chk("zw_busy_k2", BUSY, 0);
        step();
        chk("zw_held_noreq", M_REQ, 0);
        READ = 1'b0;
        step();

        // Three-wait write; inputs change after accept and must not leak through
        WRITE = 1'b1; ADDR = 26'h0000020; WDATA = 32'h12345678; M_RDATA = 32'hCAFEF00D;
        step();
        ADDR = 26'h3FFFFFF; WDATA = 32'hFFFFFFFF;
        chk("wr_req_k", M_REQ, 1);
        chk("wr_we_k", M_WE, 1);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("wr_req_w%0d", i), M_REQ, 1);
            chk($sformatf("wr_addr_w%0d", i), M_ADDR, 26'h0000020);
            chk($sformatf("wr_wdata_w%0d", i), M_WDATA, 32'h12345678);
            chk($sformatf("wr_done_w%0d", i), DONE, 0);
        end
        M_ACK = 1'b1;
        step();
        M_ACK = 1'b0;
        chk("wr_done", DONE, 1);
        chk("wr_req_low", M_REQ, 0);
        chk("wr_rdata_kept", RDATA, 32'hDEADBEEF);
        WRITE = 1'b0;
        step(); step();

        // READ held for 10 cycles with an always-acking memory
        READ = 1'b1; ADDR = 26'h0000030; M_RDATA = 32'hA5A5A5A5; M_ACK = 1'b1;
        accesses = 0; prev_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (M_REQ && !prev_req) accesses++;
            prev_req = M_REQ;
        end
        chk("held_one_access", accesses, 1);
        chk("held_rdata", RDATA, 32'hA5A5A5A5);

        // One-cycle drop of READ re-arms the strobe
        READ = 1'b0;
        step();
        READ = 1'b1; M_RDATA = 32'h5A5A5A5A;
        accesses = 0; prev_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (M_REQ && !prev_req) accesses++;
            prev_req = M_REQ;
        end
        chk("rearm_one_access", accesses, 1);
        chk("rearm_rdata", RDATA, 32'h5A5A5A5A);

        // READ and WRITE together are a no-op
        WRITE = 1'b1;
        accesses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (M_REQ) accesses++;
        end
        chk("both_no_req", accesses, 0);
        READ = 1'b0; WRITE = 1'b0; M_ACK = 1'b0;
        step();

        // Memory that never acknowledges
        READ = 1'b1; ADDR = 26'h0000040; M_RDATA = 32'h11111111;
        step();
`ifdef MEM_BUS_TIMEOUT_EN
        n = 0;
        while (M_REQ && n < 40) begin
            n++;
            chk("to_no_done", DONE, 0);
            step();
        end
        chk("to_req_cycles", n, 15);
        chk("to_err", ERR, 1);
        chk("to_done", DONE, 0);
        step();
        chk("to_err_pulse", ERR, 0);
        chk("to_busy_idle", BUSY, 0);
        chk("to_rdata_kept", RDATA, 32'h5A5A5A5A);
`else
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (M_REQ) n++;
            step();
        end
        chk("noto_req_held", n, 30);
        chk("noto_err", ERR, 0);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("noto_rst_rdata", RDATA, 0);
`endif
        READ = 1'b0;
        step();

        // Reset during the second ACCESS cycle, with an ack in that same cycle
        READ = 1'b1; ADDR = 26'h0000044; M_RDATA = 32'h77777777;
        step();
        chk("rm_req_k", M_REQ, 1);
        step();
        chk("rm_req_k1", M_REQ, 1);
        RST = 1'b1; M_ACK = 1'b1;
        step();
        chk("rm_req", M_REQ, 0);
        chk("rm_done", DONE, 0);
        chk("rm_rdata", RDATA, 0);
        chk("rm_busy", BUSY, 0);
        chk("rm_addr", M_ADDR, 0);
        chk("rm_we", M_WE, 0);
        RST = 1'b0; READ = 1'b0;
        step();
        chk("stray_ack_req", M_REQ, 0);
        chk("stray_ack_done", DONE, 0);
        chk("stray_ack_rdata", RDATA, 0);
        M_ACK = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
